// File: rtl/csr_tohost_drain_if.sv
// csr_tohost_drain_if: CSR snoop inputs, host drain stream and status outputs of the tohost drain.
interface csr_tohost_drain_if #(
  parameter int DWIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNT_WIDTH = 8
);
  localparam int OW = $clog2(DEPTH) + 1;
  logic csr_we;
  logic [11:0] csr_addr;
  logic [DWIDTH-1:0] csr_data_in;
  logic out_valid;
  logic out_ready;
  logic [DWIDTH-1:0] out_data;
  logic [OW-1:0] occupancy;
  logic [DWIDTH-1:0] tohost_last;
  logic overflow;
  logic [CNT_WIDTH-1:0] drop_count;
  logic clear_status;
  modport master (
    output csr_we, csr_addr, csr_data_in, out_ready, clear_status,
    input out_valid, out_data, occupancy, tohost_last, overflow, drop_count
  );
  modport slave (
    input csr_we, csr_addr, csr_data_in, out_ready, clear_status,
    output out_valid, out_data, occupancy, tohost_last, overflow, drop_count
  );
endinterface

// File: rtl/csr_tohost_drain.sv
// csr_tohost_drain: captures CSR writes to tohost into a FIFO drained over valid/ready, with
// last-value, sticky overflow and saturating drop-count status.
module csr_tohost_drain #(
  parameter int DWIDTH = 32,
  parameter logic [11:0] TOHOST_ADDR = 12'h51E,
  parameter int DEPTH = 4,
  parameter int CNT_WIDTH = 8
) (
  input logic clk,
  input logic rst,
  csr_tohost_drain_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;
  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [OW-1:0] occ_q, occ_d;
  logic [DWIDTH-1:0] last_q, last_d;
  logic ovf_q, ovf_d;
  logic [CNT_WIDTH-1:0] drop_q, drop_d;
  logic match, pop, push, drop;
  always_comb begin
    match = bus.csr_we && (bus.csr_addr == TOHOST_ADDR);
    pop = (occ_q != '0) && bus.out_ready;
    push = match && ((occ_q != OW'(DEPTH)) || pop);
    drop = match && !push;
    rd_d = pop ? rd_q + AW'(1) : rd_q;
    wr_d = push ? wr_q + AW'(1) : wr_q;
    occ_d = occ_q + OW'(push) - OW'(pop);
    last_d = match ? bus.csr_data_in : last_q;
    ovf_d = drop || (ovf_q && !bus.clear_status);
    // a drop in the clear cycle restarts the count at one
    drop_d = drop ? (bus.clear_status ? CNT_WIDTH'(1) : drop_q + CNT_WIDTH'(~&drop_q))
                  : (bus.clear_status ? '0 : drop_q);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q <= '0;
      wr_q <= '0;
      occ_q <= '0;
      last_q <= '0;
      ovf_q <= 1'b0;
      drop_q <= '0;
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
      occ_q <= occ_d;
      last_q <= last_d;
      ovf_q <= ovf_d;
      drop_q <= drop_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= bus.csr_data_in;
  end
  assign bus.out_valid = occ_q != '0;
  assign bus.out_data = (occ_q != '0) ? mem_q[rd_q] : '0;
  assign bus.occupancy = occ_q;
  assign bus.tohost_last = last_q;
  assign bus.overflow = ovf_q;
  assign bus.drop_count = drop_q;
endmodule

// File: tb/tb_csr_tohost_drain.sv
// tb_csr_tohost_drain: directed vector table plus hand sequences for saturation and async reset.
module tb_csr_tohost_drain;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  csr_tohost_drain_if #(.DWIDTH(32), .DEPTH(4), .CNT_WIDTH(8)) bus ();
  csr_tohost_drain #(.DWIDTH(32), .TOHOST_ADDR(12'h51E), .DEPTH(4), .CNT_WIDTH(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic we;
    logic [11:0] addr;
    logic [31:0] data;
    logic rdy;
    logic clr;
    logic ev;
    logic [31:0] ed;
    logic [2:0] eo;
    logic [31:0] el;
    logic eovf;
    logic [7:0] edr;
  } vec_t;
  vec_t tbl[$];
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", n, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic we, input logic [11:0] a, input logic [31:0] d,
                       input logic rdy, input logic clr);
    bus.csr_we = we;
    bus.csr_addr = a;
    bus.csr_data_in = d;
    bus.out_ready = rdy;
    bus.clear_status = clr;
  endtask
  task automatic chk_all(input string n, input logic ev, input logic [31:0] ed, input logic [2:0] eo,
                         input logic [31:0] el, input logic eovf, input logic [7:0] edr);
    chk({n, ".valid"}, 32'(bus.out_valid), 32'(ev));
    chk({n, ".data"}, bus.out_data, ed);
    chk({n, ".occ"}, 32'(bus.occupancy), 32'(eo));
    chk({n, ".last"}, bus.tohost_last, el);
    chk({n, ".ovf"}, 32'(bus.overflow), 32'(eovf));
    chk({n, ".drop"}, 32'(bus.drop_count), 32'(edr));
  endtask
  initial begin
    tbl.push_back(vec_t'{1, 12'h51F, 32'hDEAD, 0, 0, 0, 0, 0, 0, 0, 0});
    tbl.push_back(vec_t'{1, 12'h300, 32'hDEAD, 0, 0, 0, 0, 0, 0, 0, 0});
    tbl.push_back(vec_t'{1, 12'h51E, 32'h1, 0, 0, 1, 32'h1, 1, 32'h1, 0, 0});
    for (int i = 0; i < 5; i++) tbl.push_back(vec_t'{0, 0, 0, 0, 0, 1, 32'h1, 1, 32'h1, 0, 0});
    tbl.push_back(vec_t'{0, 0, 0, 1, 0, 0, 0, 0, 32'h1, 0, 0});
    tbl.push_back(vec_t'{1, 12'h51E, 10, 0, 0, 1, 10, 1, 10, 0, 0});
    tbl.push_back(vec_t'{1, 12'h51E, 11, 0, 0, 1, 10, 2, 11, 0, 0});
    tbl.push_back(vec_t'{1, 12'h51E, 12, 0, 0, 1, 10, 3, 12, 0, 0});
    tbl.push_back(vec_t'{1, 12'h51E, 13, 0, 0, 1, 10, 4, 13, 0, 0});
    tbl.push_back(vec_t'{1, 12'h51E, 14, 0, 0, 1, 10, 4, 14, 1, 1});
    tbl.push_back(vec_t'{0, 0, 0, 1, 0, 1, 11, 3, 14, 1, 1});
    tbl.push_back(vec_t'{0, 0, 0, 1, 0, 1, 12, 2, 14, 1, 1});
    tbl.push_back(vec_t'{0, 0, 0, 1, 0, 1, 13, 1, 14, 1, 1});
    tbl.push_back(vec_t'{0, 0, 0, 1, 0, 0, 0, 0, 14, 1, 1});
    tbl.push_back(vec_t'{1, 12'h51E, 32'hA, 0, 0, 1, 32'hA, 1, 32'hA, 1, 1});
    tbl.push_back(vec_t'{1, 12'h51E, 32'hB, 0, 0, 1, 32'hA, 2, 32'hB, 1, 1});
    tbl.push_back(vec_t'{1, 12'h51E, 32'hC, 0, 0, 1, 32'hA, 3, 32'hC, 1, 1});
    tbl.push_back(vec_t'{1, 12'h51E, 32'hD, 0, 0, 1, 32'hA, 4, 32'hD, 1, 1});
    tbl.push_back(vec_t'{1, 12'h51E, 32'hE, 1, 0, 1, 32'hB, 4, 32'hE, 1, 1});
    tbl.push_back(vec_t'{0, 0, 0, 1, 0, 1, 32'hC, 3, 32'hE, 1, 1});
    tbl.push_back(vec_t'{0, 0, 0, 1, 0, 1, 32'hD, 2, 32'hE, 1, 1});
    tbl.push_back(vec_t'{0, 0, 0, 1, 0, 1, 32'hE, 1, 32'hE, 1, 1});
    tbl.push_back(vec_t'{0, 0, 0, 1, 0, 0, 0, 0, 32'hE, 1, 1});
    tbl.push_back(vec_t'{0, 0, 0, 0, 1, 0, 0, 0, 32'hE, 0, 0});
    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    tick();
    tick();
    rst = 1'b0;
    chk_all("reset", 0, 0, 0, 0, 0, 0);
    foreach (tbl[i]) begin
      drive(tbl[i].we, tbl[i].addr, tbl[i].data, tbl[i].rdy, tbl[i].clr);
      tick();
      chk_all($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ed, tbl[i].eo, tbl[i].el, tbl[i].eovf, tbl[i].edr);
    end
    for (int i = 0; i < 300; i++) begin
      drive(1, 12'h51E, 32'(i), 0, 0);
      tick();
      if (i == 257) chk("sat.pre", 32'(bus.drop_count), 254);
    end
    chk_all("sat", 1, 0, 4, 299, 1, 255);
    drive(1, 12'h51E, 32'h1234, 0, 1);
    tick();
    chk_all("clr_drop", 1, 0, 4, 32'h1234, 1, 1);
    drive(0, 0, 0, 0, 1);
    tick();
    chk_all("clr_lone", 1, 0, 4, 32'h1234, 0, 0);
    drive(1, 12'h51E, 32'h55, 0, 0);
    tick();
    chk_all("pre_rst_drop", 1, 0, 4, 32'h55, 1, 1);
    drive(0, 0, 0, 1, 0);
    tick();
    chk_all("pre_rst_pop", 1, 1, 3, 32'h55, 1, 1);
    #2 rst = 1'b1;
    #1;
    chk_all("async_rst", 0, 0, 0, 0, 0, 0);
    #1 rst = 1'b0;
    drive(1, 12'h51E, 32'h7, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    chk_all("post_rst_w", 1, 32'h7, 1, 32'h7, 0, 0);
    drive(0, 0, 0, 1, 0);
    tick();
    chk_all("post_rst_drain", 0, 0, 0, 32'h7, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/csr_tohost_drain.md
Name: csr_tohost_drain

Overview:
- Host-side consumer of the core's CSR write path.
- Snoops every CSR write and captures those addressed to the tohost CSR (12'h51E) into a small FIFO.
- Presents captured words to the host/test harness over a valid/ready stream.
- Keeps a last-value register, a sticky overflow flag and a saturating drop counter for test pass/fail reporting.

Parameters:
- DWIDTH, 32, CSR data width.
- TOHOST_ADDR, 12'h51E, CSR address captured.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- CNT_WIDTH, 8, width of drop counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- csr_we  input  1  CSR write strobe from the core.
- csr_addr  input  12  CSR address of the write.
- csr_data_in  input  DWIDTH  final value written to the CSR.
- out_valid  output  1  FIFO non-empty; head word presented.
- out_ready  input  1  host accepts the head word.
- out_data  output  DWIDTH  head word; 0 when out_valid=0.
- occupancy  output  log2(DEPTH)+1  number of stored entries.
- tohost_last  output  DWIDTH  most recent matching write value.
- overflow  output  1  sticky; a matching write was dropped.
- drop_count  output  CNT_WIDTH  dropped writes, saturating.
- clear_status  input  1  synchronous clear of overflow and drop_count.

Behaviour:
- Reset, asynchronous, any cycle including mid-transfer: pointers=0, occupancy=0, out_valid=0, out_data=0, tohost_last=0, overflow=0, drop_count=0. FIFO storage is not reset.
- match = csr_we && (csr_addr == TOHOST_ADDR). Writes to any other address are ignored.
- tohost_last <= csr_data_in on every match, whether or not the FIFO accepts it.
- pop = out_valid && out_ready. pop has no effect when out_valid=0.
- Push condition: match && (occupancy < DEPTH || pop).
  - A full FIFO with a simultaneous pop accepts the write.
  - occupancy is unchanged on push+pop, +1 on push only, -1 on pop only.
- No bypass path. A push into an empty FIFO raises out_valid on the next cycle, so write-to-visible latency is 1 cycle.
- out_valid = (occupancy != 0). out_data is the storage at the read pointer, combinational from registered state, forced to 0 when empty.
- The head word holds stable while out_valid=1 && out_ready=0.
- Read and write pointers wrap modulo DEPTH. Ordering is strictly FIFO.
- Drop condition: match && occupancy == DEPTH && !pop.
  - Data is discarded.
  - overflow <= 1.
  - drop_count increments and saturates at 2^CNT_WIDTH-1.
- clear_status: overflow <= 0, drop_count <= 0.
  - A drop in the same cycle as clear_status wins: overflow=1, drop_count=1.
- Back-to-back matches on consecutive cycles are all captured while space remains.
- No combinational path from csr_* to any output. out_data and out_valid do not depend combinationally on out_ready.

Test Plan:
- Reset, then a single write csr_we=1, addr=12'h51E, data=32'h1. Required: next cycle out_valid=1, out_data=32'h1, occupancy=1, tohost_last=32'h1. Hold out_ready=0 for 5 cycles: data stable. Pulse out_ready: out_valid=0, out_data=0.
- Writes to 12'h51F and 12'h300 with data 32'hDEAD. Required: occupancy=0, tohost_last=0, out_valid=0.
- Five consecutive matching writes 10..14 with out_ready=0 and DEPTH=4. Required: occupancy=4, overflow=1, drop_count=1, tohost_last=14. Drain order 10,11,12,13.
- Full FIFO (A,B,C,D), then a matching write E in the same cycle as a pop. Required: no drop, occupancy stays 4, drain order B,C,D,E.
- Write 300 matching values with out_ready=0. Required: drop_count saturates at 255. clear_status together with one more dropped write gives overflow=1, drop_count=1. A lone clear_status then gives 0 and 0.
- Assert rst asynchronously between clock edges with occupancy=3 while out_ready=1. Required: out_valid, occupancy, overflow and tohost_last go to 0 immediately, without waiting for a clock edge. A post-reset write of 32'h7 drains as 32'h7 only.
